// File: rtl/disp_pkg.sv
// Shared constants for the display output stage: mode encodings and the
// colour-bar on/off table.
package disp_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_BG    = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;
    localparam logic [1:0] MODE_BLANK = 2'd3;

    // {r,g,b} full-scale mask per bar: white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            3'd7:    m = 3'b000;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/disp_out_stage_bpc_expand.sv
// Combinational channel width converter: MSB-first bit replication when
// widening, keeps the top bits when narrowing.
module bpc_expand #(
    parameter int BPC       = 5,
    parameter int BPC_BOARD = 8
) (
    input  logic [BPC-1:0]       din,
    output logic [BPC_BOARD-1:0] dout
);

    // output bit i (from the MSB) takes input bit (i mod BPC) from the MSB
    always_comb begin
        dout = '0;
        for (int i = 0; i < BPC_BOARD; i++) begin
            dout[BPC_BOARD-1-i] = din[BPC-1-(i % BPC)];
        end
    end

endmodule

// File: rtl/disp_out_stage.sv
// Display output stage: frame-locked source select, colour-bar generator and
// BPC -> BPC_BOARD expansion with a fixed 2-cycle timing-aligned pipeline.
module disp_out_stage
    import disp_pkg::*;
#(
    parameter int               BPC       = 5,
    parameter int               BPC_BOARD = 8,
    parameter int               H_RES     = 1366,
    parameter logic [3*BPC-1:0] BG_COLR   = 15'h0886,
    parameter logic [1:0]       MODE_INIT = 2'd0
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix_n,
    input  logic [1:0]           mode_req,
    input  logic                 disp_hsync,
    input  logic                 disp_vsync,
    input  logic                 disp_de,
    input  logic                 disp_frame,
    input  logic [BPC-1:0]       disp_r,
    input  logic [BPC-1:0]       disp_g,
    input  logic [BPC-1:0]       disp_b,
    output logic                 board_hsync,
    output logic                 board_vsync,
    output logic                 board_de,
    output logic                 board_frame,
    output logic [BPC_BOARD-1:0] board_r,
    output logic [BPC_BOARD-1:0] board_g,
    output logic [BPC_BOARD-1:0] board_b,
    output logic [1:0]           mode_act
);

    localparam int              BAR_W    = H_RES / 8;
    localparam int              PW       = $clog2(BAR_W + 1);
    localparam logic [PW-1:0]   PIX_LAST = PW'(BAR_W - 1);

    logic           prev_de_r;
    logic [PW-1:0]  pix_cnt_r;
    logic [2:0]     bar_idx_r;
    logic [PW-1:0]  cur_pix_s;
    logic [2:0]     cur_bar_s;
    logic [2:0]     bar_mask_s;
    logic [BPC-1:0] src_r_s, src_g_s, src_b_s;
    logic [BPC-1:0] s1_r_r, s1_g_r, s1_b_r;
    logic           s1_hs_r, s1_vs_r, s1_de_r, s1_fr_r;
    logic [BPC_BOARD-1:0] exp_r_s, exp_g_s, exp_b_s;

    // mode register, reloaded only while the controller flags a frame boundary
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            mode_act <= MODE_INIT;
        end else if (disp_frame) begin
            mode_act <= mode_req;
        end else begin
            mode_act <= mode_act;
        end
    end

    // position of the current pixel; the first de cycle of a line is bar 0, pixel 0
    always_comb begin
        if (disp_de && !prev_de_r) begin
            cur_pix_s = '0;
            cur_bar_s = 3'd0;
        end else begin
            cur_pix_s = pix_cnt_r;
            cur_bar_s = bar_idx_r;
        end
    end

    // bar counters advance past the current pixel; bar 7 absorbs any remainder
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            prev_de_r <= 1'b0;
            pix_cnt_r <= '0;
            bar_idx_r <= 3'd0;
        end else begin
            prev_de_r <= disp_de;
            if (disp_de) begin
                if (cur_pix_s == PIX_LAST) begin
                    pix_cnt_r <= '0;
                    bar_idx_r <= (cur_bar_s == 3'd7) ? cur_bar_s : cur_bar_s + 3'd1;
                end else begin
                    pix_cnt_r <= cur_pix_s + PW'(1);
                    bar_idx_r <= cur_bar_s;
                end
            end else begin
                pix_cnt_r <= pix_cnt_r;
                bar_idx_r <= bar_idx_r;
            end
        end
    end

    // source select for stage 1
    always_comb begin
        src_r_s    = '0;
        src_g_s    = '0;
        src_b_s    = '0;
        bar_mask_s = bar_mask(cur_bar_s);
        case (mode_act)
            MODE_PASS: begin
                src_r_s = disp_r;
                src_g_s = disp_g;
                src_b_s = disp_b;
            end
            MODE_BG: begin
                src_r_s = BG_COLR[3*BPC-1:2*BPC];
                src_g_s = BG_COLR[2*BPC-1:BPC];
                src_b_s = BG_COLR[BPC-1:0];
            end
            MODE_BARS: begin
                src_r_s = {BPC{bar_mask_s[2]}};
                src_g_s = {BPC{bar_mask_s[1]}};
                src_b_s = {BPC{bar_mask_s[0]}};
            end
            MODE_BLANK: begin
                src_r_s = '0;
                src_g_s = '0;
                src_b_s = '0;
            end
            default: begin
                src_r_s = '0;
                src_g_s = '0;
                src_b_s = '0;
            end
        endcase
    end

    // stage 1 registers: selected colour plus aligned timing
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            s1_r_r  <= '0;
            s1_g_r  <= '0;
            s1_b_r  <= '0;
            s1_hs_r <= 1'b0;
            s1_vs_r <= 1'b0;
            s1_de_r <= 1'b0;
            s1_fr_r <= 1'b0;
        end else begin
            s1_r_r  <= src_r_s;
            s1_g_r  <= src_g_s;
            s1_b_r  <= src_b_s;
            s1_hs_r <= disp_hsync;
            s1_vs_r <= disp_vsync;
            s1_de_r <= disp_de;
            s1_fr_r <= disp_frame;
        end
    end

    bpc_expand #(.BPC(BPC), .BPC_BOARD(BPC_BOARD)) u_exp_r (.din(s1_r_r), .dout(exp_r_s));
    bpc_expand #(.BPC(BPC), .BPC_BOARD(BPC_BOARD)) u_exp_g (.din(s1_g_r), .dout(exp_g_s));
    bpc_expand #(.BPC(BPC), .BPC_BOARD(BPC_BOARD)) u_exp_b (.din(s1_b_r), .dout(exp_b_s));

    // stage 2 registers: expanded colour, blanked outside the active region
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            board_hsync <= 1'b0;
            board_vsync <= 1'b0;
            board_de    <= 1'b0;
            board_frame <= 1'b0;
            board_r     <= '0;
            board_g     <= '0;
            board_b     <= '0;
        end else begin
            board_hsync <= s1_hs_r;
            board_vsync <= s1_vs_r;
            board_de    <= s1_de_r;
            board_frame <= s1_fr_r;
            board_r     <= s1_de_r ? exp_r_s : '0;
            board_g     <= s1_de_r ? exp_g_s : '0;
            board_b     <= s1_de_r ? exp_b_s : '0;
        end
    end

endmodule

// File: tb/tb_disp_out_stage.sv
// Self-checking bench for disp_out_stage (BPC 5 -> 8, H_RES 20) with a
// latency-2 scoreboard plus standalone width-converter sweeps.
module tb_disp_out_stage;

    logic       clk_pix = 1'b0;
    logic       rst_pix_n = 1'b0;
    logic [1:0] mode_req = 2'd0;
    logic       disp_hsync = 1'b0, disp_vsync = 1'b0, disp_de = 1'b0, disp_frame = 1'b0;
    logic [4:0] disp_r = 5'd0, disp_g = 5'd0, disp_b = 5'd0;
    logic       board_hsync, board_vsync, board_de, board_frame;
    logic [7:0] board_r, board_g, board_b;
    logic [1:0] mode_act;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fr;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          m_mode = 0;
    bit          m_prev_de = 1'b0;
    int          m_x = 0;
    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic [3:0] w48_in;  logic [7:0] w48_out;
    logic [4:0] w510_in; logic [9:0] w510_out;
    logic [7:0] w85_in;  logic [4:0] w85_out;
    logic [0:0] w18_in;  logic [7:0] w18_out;

    disp_out_stage #(
        .BPC(5), .BPC_BOARD(8), .H_RES(20), .BG_COLR(15'h0886), .MODE_INIT(2'd0)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode_req(mode_req),
        .disp_hsync(disp_hsync), .disp_vsync(disp_vsync), .disp_de(disp_de),
        .disp_frame(disp_frame), .disp_r(disp_r), .disp_g(disp_g), .disp_b(disp_b),
        .board_hsync(board_hsync), .board_vsync(board_vsync), .board_de(board_de),
        .board_frame(board_frame), .board_r(board_r), .board_g(board_g),
        .board_b(board_b), .mode_act(mode_act)
    );

    bpc_expand #(.BPC(4), .BPC_BOARD(8))  u_w48  (.din(w48_in),  .dout(w48_out));
    bpc_expand #(.BPC(5), .BPC_BOARD(10)) u_w510 (.din(w510_in), .dout(w510_out));
    bpc_expand #(.BPC(8), .BPC_BOARD(5))  u_w85  (.din(w85_in),  .dout(w85_out));
    bpc_expand #(.BPC(1), .BPC_BOARD(8))  u_w18  (.din(w18_in),  .dout(w18_out));

    always #5 clk_pix = ~clk_pix;

    function automatic logic [7:0] x58(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    // one pixel per cycle: drive inputs just after the edge and queue the expected output
    task automatic drive(input logic hs, input logic vs, input logic de, input logic fr,
                         input logic [1:0] mreq, input logic [4:0] r, input logic [4:0] g,
                         input logic [4:0] b);
        exp_t e;
        int   bi;
        @(posedge clk_pix);
        #1;
        disp_hsync = hs; disp_vsync = vs; disp_de = de; disp_frame = fr;
        mode_req = mreq; disp_r = r; disp_g = g; disp_b = b;
        if (de) m_x = m_prev_de ? m_x + 1 : 0;
        m_prev_de = de;
        e.hs = hs; e.vs = vs; e.de = de; e.fr = fr;
        case (m_mode)
            0:       begin e.r = x58(r); e.g = x58(g); e.b = x58(b); end
            1:       begin e.r = 8'h10; e.g = 8'h21; e.b = 8'h31; end
            2:       begin
                         bi = (m_x / 2 > 7) ? 7 : m_x / 2;
                         {e.r, e.g, e.b} = bar_rgb[bi];
                     end
            default: begin e.r = 8'h00; e.g = 8'h00; e.b = 8'h00; end
        endcase
        if (!de) begin e.r = 8'h00; e.g = 8'h00; e.b = 8'h00; end
        if (fr) m_mode = int'(mreq);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, mode_req, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic set_mode(input logic [1:0] m);
        drive(1'b0, 1'b1, 1'b0, 1'b1, m, 5'd0, 5'd0, 5'd0);
        idle(1);
        checks++;
        if (mode_act !== m) begin
            errors++;
            $display("FAIL mode_capture: mode_act=%0d expected %0d", mode_act, m);
        end
    endtask

    // scoreboard: output after edge k matches input driven after edge k-2
    always @(negedge clk_pix) begin
        exp_t e;
        if (rst_pix_n && sb.size() >= 3) begin
            e = sb.pop_front();
            checks++;
            if ({board_hsync, board_vsync, board_de, board_frame, board_r, board_g, board_b} !== e) begin
                errors++;
                $display("FAIL pipeline: got hs=%b vs=%b de=%b fr=%b rgb=%h/%h/%h expected hs=%b vs=%b de=%b fr=%b rgb=%h/%h/%h",
                         board_hsync, board_vsync, board_de, board_frame, board_r, board_g, board_b,
                         e.hs, e.vs, e.de, e.fr, e.r, e.g, e.b);
            end
        end
    end

    task automatic do_async_reset();
        #2;
        rst_pix_n = 1'b0;
        #1;
        checks++;
        if ({board_hsync, board_vsync, board_de, board_frame, board_r, board_g, board_b} !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {board_hsync, board_vsync, board_de, board_frame, board_r, board_g, board_b});
        end
        checks++;
        if (mode_act !== 2'd0) begin
            errors++;
            $display("FAIL reset_mode: mode_act=%0d expected 0", mode_act);
        end
        sb.delete();
        m_mode = 0; m_prev_de = 1'b0; m_x = 0;
        repeat (3) @(posedge clk_pix);
        #1;
        rst_pix_n = 1'b1;
    endtask

    task automatic test_reset();
        disp_hsync = 1'b0; disp_vsync = 1'b0; disp_de = 1'b0; disp_frame = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1;
        checks++;
        if ({board_de, board_r, board_g, board_b, mode_act} !== 27'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {board_de, board_r, board_g, board_b, mode_act});
        end
        rst_pix_n = 1'b1;
        idle(2);
    endtask

    task automatic test_pass();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'h11, 5'h1F, 5'h00);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'h0A, 5'h15, 5'h1F);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'h01, 5'h10, 5'h07);
        checks++;
        if ({board_r, board_g, board_b} !== 24'h8CFF00) begin
            errors++;
            $display("FAIL pass_5to8: got %h expected 8cff00", {board_r, board_g, board_b});
        end
        for (int i = 0; i < 6; i++)
            drive(1'(i), 1'(i >> 1), 1'b1, 1'b0, 2'd0, 5'($urandom), 5'($urandom), 5'($urandom));
        // hsync/vsync must still propagate with de low and colour present on the inputs
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'h1F, 5'h1F, 5'h1F);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'h1F, 5'h1F, 5'h1F);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 5'h1F, 5'h1F, 5'h1F);
        idle(2);
    endtask

    task automatic test_background();
        set_mode(2'd1);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 5'($urandom), 5'($urandom), 5'($urandom));
        checks++;
        if ({board_r, board_g, board_b} !== 24'h102131) begin
            errors++;
            $display("FAIL background: got %h expected 102131", {board_r, board_g, board_b});
        end
        idle(2);
    endtask

    task automatic test_bars();
        set_mode(2'd2);
        for (int line = 0; line < 2; line++) begin
            for (int i = 0; i < 20; i++)
                drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 5'($urandom), 5'($urandom), 5'($urandom));
            idle(3);
        end
    endtask

    task automatic test_frame_switch();
        set_mode(2'd0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'($urandom), 5'($urandom), 5'($urandom));
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 5'($urandom), 5'($urandom), 5'($urandom));
        checks++;
        if (mode_act !== 2'd0) begin
            errors++;
            $display("FAIL mode_hold: mode_act=%0d expected 0", mode_act);
        end
        idle(2);
        set_mode(2'd3);
        for (int i = 0; i < 5; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 5'h1F, 5'h1F, 5'h1F);
        idle(2);
    endtask

    task automatic test_reset_midline();
        set_mode(2'd2);
        for (int i = 0; i < 7; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0);
        do_async_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 6; i++)
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0);
        idle(3);
    endtask

    task automatic test_width_sweep();
        logic [3:0]  v4  [2] = '{4'hF, 4'hA};
        logic [7:0]  e48 [2] = '{8'hFF, 8'hAA};
        logic [4:0]  v5  [2] = '{5'h1F, 5'h11};
        logic [9:0]  e510[2] = '{10'h3FF, 10'h231};
        logic [7:0]  v8  [2] = '{8'hFF, 8'hA5};
        logic [4:0]  e85 [2] = '{5'h1F, 5'h14};
        logic [0:0]  v1  [2] = '{1'b1, 1'b0};
        logic [7:0]  e18 [2] = '{8'hFF, 8'h00};
        for (int i = 0; i < 2; i++) begin
            w48_in = v4[i]; w510_in = v5[i]; w85_in = v8[i]; w18_in = v1[i];
            #1;
            checks += 4;
            if (w48_out !== e48[i]) begin
                errors++; $display("FAIL width_4_8: got %h expected %h", w48_out, e48[i]);
            end
            if (w510_out !== e510[i]) begin
                errors++; $display("FAIL width_5_10: got %h expected %h", w510_out, e510[i]);
            end
            if (w85_out !== e85[i]) begin
                errors++; $display("FAIL width_8_5: got %h expected %h", w85_out, e85[i]);
            end
            if (w18_out !== e18[i]) begin
                errors++; $display("FAIL width_1_8: got %h expected %h", w18_out, e18[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_background();
        test_bars();
        test_frame_switch();
        test_reset_midline();
        test_width_sweep();
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
